// File: rtl/fetch_queue.sv
// Fetch queue: issues PCs to instruction memory and pairs in-order responses with their PCs.
// Optional predecode flag on the decode side when FETCH_QUEUE_PREDECODE_EN is defined.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_instr,
  input  logic            dec_ready,
`ifdef FETCH_QUEUE_PREDECODE_EN
  output logic            dec_is_ctrl,
`endif
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StDrain = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] head_q, fill_q, alloc_q;
  logic [PW-1:0] drop_q, drop_d;
  logic [PW-1:0] occ, inflight;

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [DEPTH-1:0] filled_q;

  logic run, credit, issue, rsp_acc, deq;
  logic [AW-1:0] head_idx, fill_idx, alloc_idx;

  assign head_idx  = head_q[AW-1:0];
  assign fill_idx  = fill_q[AW-1:0];
  assign alloc_idx = alloc_q[AW-1:0];

  assign occ      = alloc_q - head_q;
  assign inflight = alloc_q - fill_q;
  assign run      = (state_q == StRun);
  assign credit   = (occ < PW'(DEPTH));

  assign imem_req_valid = pc_valid & credit & run & ~flush;
  assign pc_ready       = imem_req_ready & credit & run & ~flush;
  assign imem_req_addr  = pc_in;

  assign issue   = pc_valid & pc_ready;
  // A response with nothing outstanding is a protocol error and is dropped.
  assign rsp_acc = imem_rsp_valid & run & ~flush & (fill_q != alloc_q);

  assign dec_valid = filled_q[head_idx] & (occ != '0);
  assign dec_pc    = pc_mem[head_idx];
  assign dec_instr = instr_mem[head_idx];
  assign deq       = dec_valid & dec_ready & ~flush;
  assign occupancy = occ;

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    if (flush) begin
      // Responses still owed for issued-but-unfilled entries must be swallowed.
      drop_d = drop_q + inflight;
      if (imem_rsp_valid && drop_d != '0) drop_d = drop_d - PW'(1);
      state_d = (drop_d != '0) ? StDrain : StRun;
    end else if (state_q == StDrain) begin
      if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - PW'(1);
      if (drop_d == '0) state_d = StRun;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      drop_q  <= '0;
      head_q  <= '0;
      fill_q  <= '0;
      alloc_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (flush) begin
        head_q  <= '0;
        fill_q  <= '0;
        alloc_q <= '0;
      end else begin
        if (issue)   alloc_q <= alloc_q + PW'(1);
        if (rsp_acc) fill_q  <= fill_q + PW'(1);
        if (deq)     head_q  <= head_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
      filled_q <= '0;
    end else begin
      if (issue) begin
        pc_mem[alloc_idx]   <= pc_in;
        filled_q[alloc_idx] <= 1'b0;
      end
      if (rsp_acc) begin
        instr_mem[fill_idx] <= imem_rsp_data;
        filled_q[fill_idx]  <= 1'b1;
      end
    end
  end

`ifdef FETCH_QUEUE_PREDECODE_EN
  logic [DEPTH-1:0] ctrl_q;
  logic             rsp_is_ctrl;

  assign rsp_is_ctrl = (imem_rsp_data[6:0] == 7'b1100011) ||
                       (imem_rsp_data[6:0] == 7'b1101111) ||
                       (imem_rsp_data[6:0] == 7'b1100111);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
    end else begin
      if (issue)   ctrl_q[alloc_idx] <= 1'b0;
      if (rsp_acc) ctrl_q[fill_idx]  <= rsp_is_ctrl;
    end
  end

  assign dec_is_ctrl = ctrl_q[head_idx] & dec_valid;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, XLEN=32).
module tb_fetch_queue;

  logic        clk, reset;
  logic [31:0] pc_in, imem_req_addr, imem_rsp_data, dec_pc, dec_instr;
  logic        pc_valid, pc_ready, flush, imem_req_valid, imem_req_ready;
  logic        imem_rsp_valid, dec_valid, dec_ready;
  logic [2:0]  occupancy;
`ifdef FETCH_QUEUE_PREDECODE_EN
  logic        dec_is_ctrl;
`endif

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_in),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_pc         (dec_pc),
    .dec_instr      (dec_instr),
    .dec_ready      (dec_ready),
`ifdef FETCH_QUEUE_PREDECODE_EN
    .dec_is_ctrl    (dec_is_ctrl),
`endif
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [31:0] iw(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic pv, input logic [31:0] pc, input logic rv,
                     input logic [31:0] rd, input logic dr, input logic fl);
    pc_valid       = pv;
    pc_in          = pc;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    dec_ready      = dr;
    flush          = fl;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_dec_pc", dec_pc, 0);
    chk("rst_dec_instr", dec_instr, 0);
    chk("rst_pc_ready_mem_busy", pc_ready, 0);
`ifdef FETCH_QUEUE_PREDECODE_EN
    chk("rst_is_ctrl", dec_is_ctrl, 0);
`endif
    reset          = 1'b0;
    imem_req_ready = 1'b1;

    // Streaming, 1-cycle memory latency
    drv(1, 32'h0, 0, 0, 1, 0);
    chk("st_req_valid", imem_req_valid, 1);
    chk("st_req_addr", imem_req_addr, 32'h0);
    chk("st_pc_ready", pc_ready, 1);
    tick;
    drv(1, 32'h4, 1, iw(32'h0), 1, 0);
    chk("st_occ1", occupancy, 1);
    chk("st_not_valid_yet", dec_valid, 0);
    tick;
    drv(1, 32'h8, 1, iw(32'h4), 1, 0);
    chk("st_dv0", dec_valid, 1);
    chk("st_pc0", dec_pc, 32'h0);
    chk("st_in0", dec_instr, iw(32'h0));
    chk("st_occ2a", occupancy, 2);
    tick;
    drv(1, 32'hC, 1, iw(32'h8), 1, 0);
    chk("st_pc4", dec_pc, 32'h4);
    chk("st_occ2b", occupancy, 2);
    tick;
    drv(0, 0, 1, iw(32'hC), 1, 0);
    chk("st_pc8", dec_pc, 32'h8);
    chk("st_occ2c", occupancy, 2);
    tick;
    drv(0, 0, 0, 0, 1, 0);
    chk("st_pc12", dec_pc, 32'hC);
    chk("st_in12", dec_instr, iw(32'hC));
    chk("st_occ1b", occupancy, 1);
    tick;
    chk("st_empty_valid", dec_valid, 0);
    chk("st_empty_occ", occupancy, 0);

    // Full queue with decode stalled
    for (int k = 0; k < 4; k++) begin
      drv(1, 32'h20 + 32'(4 * k), 0, 0, 0, 0);
      chk("full_issue_ready", pc_ready, 1);
      tick;
    end
    drv(1, 32'h30, 0, 0, 0, 0);
    chk("full_pc_ready", pc_ready, 0);
    chk("full_req_valid", imem_req_valid, 0);
    chk("full_occ", occupancy, 4);
    chk("full_unfilled", dec_valid, 0);
    tick;
    drv(1, 32'h30, 0, 0, 0, 0);
    chk("full_pc_ready2", pc_ready, 0);
    tick;
    for (int k = 0; k < 4; k++) begin
      drv(1, 32'h30, 1, iw(32'h20 + 32'(4 * k)), 0, 0);
      chk("full_rsp_ready", pc_ready, 0);
      tick;
    end
    drv(1, 32'h30, 0, 0, 1, 0);
    chk("full_deq_same_cycle", pc_ready, 0);
    chk("full_head20", dec_pc, 32'h20);
    chk("full_occ4", occupancy, 4);
    tick;
    drv(1, 32'h30, 0, 0, 1, 0);
    chk("full_resume", pc_ready, 1);
    chk("full_head24", dec_pc, 32'h24);
    chk("full_occ3", occupancy, 3);
    tick;
    drv(0, 0, 0, 0, 1, 0);
    chk("full_head28", dec_pc, 32'h28);
    chk("full_occ3b", occupancy, 3);
    tick;
    chk("full_head2c", dec_pc, 32'h2C);
    tick;
    chk("full_wait30", dec_valid, 0);
    chk("full_occ1", occupancy, 1);
    drv(0, 0, 1, iw(32'h30), 1, 0);
    tick;
    drv(0, 0, 0, 0, 1, 0);
    chk("full_head30", dec_pc, 32'h30);
    chk("full_dv30", dec_valid, 1);
    tick;
    chk("full_drained", occupancy, 0);

    // Flush with 3 outstanding and 1 filled
    drv(1, 32'h40, 0, 0, 0, 0);
    tick;
    drv(1, 32'h44, 1, iw(32'h40), 0, 0);
    tick;
    drv(1, 32'h48, 0, 0, 0, 0);
    tick;
    drv(1, 32'h4C, 0, 0, 0, 0);
    tick;
    chk("fl_pre_occ", occupancy, 4);
    chk("fl_pre_pc", dec_pc, 32'h40);
    drv(1, 32'h100, 0, 0, 1, 1);
    chk("fl_ready_during", pc_ready, 0);
    chk("fl_req_during", imem_req_valid, 0);
    tick;
    drv(1, 32'h100, 0, 0, 0, 0);
    chk("fl_occ0", occupancy, 0);
    chk("fl_dv0", dec_valid, 0);
    chk("fl_drain_block", pc_ready, 0);
    for (int k = 0; k < 3; k++) begin
      drv(1, 32'h100, 1, 32'hDEAD_0000 + 32'(k), 0, 0);
      chk("fl_drop_ready", pc_ready, 0);
      chk("fl_drop_occ", occupancy, 0);
      tick;
    end
    drv(1, 32'h100, 0, 0, 0, 0);
    chk("fl_run_again", pc_ready, 1);
    chk("fl_addr100", imem_req_addr, 32'h100);
    tick;
    drv(0, 0, 1, iw(32'h100), 0, 0);
    tick;
    drv(0, 0, 0, 0, 1, 0);
    chk("fl_dv100", dec_valid, 1);
    chk("fl_pc100", dec_pc, 32'h100);
    chk("fl_in100", dec_instr, iw(32'h100));
    tick;
    chk("fl_occ_end", occupancy, 0);

    // Flush coinciding with a response and a dequeue
    drv(1, 32'h200, 0, 0, 0, 0);
    tick;
    drv(1, 32'h204, 1, iw(32'h200), 0, 0);
    tick;
    drv(1, 32'h208, 0, 0, 0, 0);
    tick;
    chk("fr_occ3", occupancy, 3);
    chk("fr_pc200", dec_pc, 32'h200);
    drv(0, 0, 1, iw(32'h204), 1, 1);
    tick;
    drv(1, 32'h300, 0, 0, 0, 0);
    chk("fr_occ0", occupancy, 0);
    chk("fr_dv0", dec_valid, 0);
    chk("fr_draining", pc_ready, 0);
    drv(1, 32'h300, 1, 32'hDEAD_BEEF, 0, 0);
    tick;
    drv(1, 32'h300, 0, 0, 0, 0);
    chk("fr_drop_one", pc_ready, 1);
    tick;
    drv(1, 32'h304, 1, iw(32'h300), 0, 0);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    chk("fr_occ2", occupancy, 2);
    chk("fr_pc300", dec_pc, 32'h300);
    chk("fr_dv300", dec_valid, 1);

    // Asynchronous reset with 2 entries queued
    reset = 1'b1;
    #1;
    chk("ar_occ", occupancy, 0);
    chk("ar_dv", dec_valid, 0);
    chk("ar_pc", dec_pc, 0);
    chk("ar_instr", dec_instr, 0);
    reset = 1'b0;
    drv(1, 32'h0, 0, 0, 0, 0);
    chk("ar_req_valid", imem_req_valid, 1);
    chk("ar_pc_ready", pc_ready, 1);
    chk("ar_addr", imem_req_addr, 32'h0);
    tick;
    chk("ar_occ1", occupancy, 1);
    drv(0, 0, 1, iw(32'h0), 1, 0);
    tick;
    drv(0, 0, 0, 0, 1, 0);
    chk("ar_dv", dec_valid, 1);
    chk("ar_pc0", dec_pc, 32'h0);
    tick;
    chk("ar_occ_end", occupancy, 0);

`ifdef FETCH_QUEUE_PREDECODE_EN
    drv(1, 32'h400, 0, 0, 0, 0);
    tick;
    drv(1, 32'h404, 1, 32'h0000_0063, 0, 0);
    tick;
    drv(0, 0, 1, 32'h0000_0013, 1, 0);
    chk("pd_pc400", dec_pc, 32'h400);
    chk("pd_branch", dec_is_ctrl, 1);
    tick;
    drv(0, 0, 0, 0, 1, 0);
    chk("pd_pc404", dec_pc, 32'h404);
    chk("pd_addi", dec_is_ctrl, 0);
    tick;
    chk("pd_empty", dec_is_ctrl, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
